layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Control block that shares one input sample among `COUNT` `node` instances forming a layer. It sequences their forward and backward handshakes, joins the node activations into one output vector, and reduces the per-node back-propagated errors into one error vector for the upstream layer. It sits between two layers: upstream-facing ports on one side, per-node ports on the other. It contains no arithmetic beyond the error reduction.

## Interface
- `WIDTH`, 8: activation width; error width is 2*WIDTH signed.
- `DEPTH`, 2: inputs per node (input vector length).
- `COUNT`, 2: nodes in the layer (output vector length), ≥2.
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `train` in 1: training mode, sampled on input accept.
- `input_forward_valid/ready` in/out 1; `input_forward_data` in DEPTH×WIDTH: upstream sample.
- `node_train` out 1: latched `train`, wired to every node.
- `node_forward_valid` out COUNT; `node_forward_data` out DEPTH×WIDTH; `node_forward_ready` in COUNT.
- `node_output_valid` in COUNT; `node_output_data` in COUNT×WIDTH; `node_output_ready` out COUNT.
- `output_forward_valid/ready` out/in 1; `output_forward_data` out COUNT×WIDTH: element k from node k.
- `input_backward_valid/ready` in/out 1; `input_backward_data` in COUNT×2WIDTH: error per node.
- `node_backward_valid` out COUNT; `node_backward_data` out COUNT×2WIDTH; `node_backward_ready` in COUNT.
- `node_error_valid` in COUNT; `node_error_data` in COUNT×DEPTH×2WIDTH; `node_error_ready` out COUNT.
- `output_backward_valid/ready` out/in 1; `output_backward_data` out DEPTH×2WIDTH: reduced error.

## Operation
- States: IDLE, SCATTER, GATHER, EMIT, DELTA, DISTRIBUTE, COLLECT, REDUCE, RETURN.
- IDLE: `input_forward_ready`=1. On handshake, register the sample and `train` into `node_train`, clear masks, go to SCATTER.
- SCATTER: `node_forward_valid[k]` = ~sent[k]. Set sent[k] on `node_forward_ready[k]`. When all sent, go to GATHER.
- Output capture is enabled in both SCATTER and GATHER. `node_output_ready[k]` = sent[k] & ~got[k]; on handshake, store into slot k and set got[k]. A fast node's output is accepted while others are still being scattered.
- GATHER: when all got, go to EMIT.
- EMIT: hold `output_forward_valid`=1 with stable data until `output_forward_ready`. Then go to DELTA if `node_train`, else IDLE.
- DELTA: `input_backward_ready`=1. On handshake, register the error vector and go to DISTRIBUTE.
- DISTRIBUTE/COLLECT mirror SCATTER/GATHER using the `node_backward_*` and `node_error_*` ports, with independent sent/got masks. Error capture is enabled in both states.
- REDUCE: counter k runs 0..COUNT-1, one node per cycle. acc[d] = acc[d] + err[k][d] for all d in parallel; acc is cleared on entry. Go to RETURN after k=COUNT-1, i.e. exactly COUNT cycles.
- RETURN: hold `output_backward_valid`=1 with `output_backward_data`=acc until `output_backward_ready`, then go to IDLE.
- Unused encodings return to IDLE.

## Timing
- Reset (`reset`=0): state IDLE. All valid outputs, `node_*_ready`, `input_backward_ready`, `node_train`, data registers, masks and counter are 0. `input_forward_ready` is forced 0 while `reset` is low.
- Reset mid-operation: immediate abort; the partial sample is discarded. Nodes share the same reset.
- Input accepted at cycle 0: `node_forward_valid` is asserted at cycle 1.
- If all nodes are ready and respond with zero latency, `output_forward_valid` rises at cycle 3.
- Valid is never deasserted and data never changes before the corresponding ready handshake.
- Per-node valid drops in the cycle after that node's handshake.
- `train` changes after accept do not affect the current sample.
- Simultaneous handshakes on any subset of nodes in one cycle are all taken.
- REDUCE adds exactly COUNT cycles between the last error capture and `output_backward_valid`.

## Configuration
- `LAYER_SEQUENCER_SATURATE_EN` defined: each REDUCE addition clamps to [-2^(2WIDTH-1), 2^(2WIDTH-1)-1].
- `LAYER_SEQUENCER_SATURATE_EN` undefined: additions wrap modulo 2^(2WIDTH).

## Test plan
All scenarios use WIDTH=8, DEPTH=2, COUNT=2.
- Reset: pull `reset` low during GATHER → all valids/readies 0 asynchronously. After release, `input_forward_ready`=1 next cycle and no stale `output_forward_valid`.
- Inference: `train`=0, sample {0x10,0x20}. Node0 ready immediately, node1 after 3 cycles; nodes return 0x80 and 0x7F → `output_forward_data`={0x80,0x7F}, then IDLE with `input_backward_ready` never asserted.
- Out-of-order gather: node1 output valid while node0 not yet scattered → node1 captured first, output vector still ordered by node index.
- Training: errors {0x0100,0xFF00} from node0 and {0x0050,0x0010} from node1 → `output_backward_data`={0x0150,0xFF10}, asserted COUNT=2 cycles after the last capture.
- Saturation: elements 0x7000+0x7000 and 0x8000+0x8000 → 0x7FFF/0x8000 with the macro, 0xE000/0x0000 without.
- Back-pressure: `output_forward_ready` held low 5 cycles → data stable, `input_forward_ready` stays 0, single transfer when released.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: shares one sample across COUNT nodes, joins their activations and reduces their errors.
// Define LAYER_SEQUENCER_SATURATE_EN to clamp each error-reduction addition instead of wrapping.
module layer_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int COUNT = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           train,
    input  logic                           input_forward_valid,
    output logic                           input_forward_ready,
    input  logic [DEPTH*WIDTH-1:0]         input_forward_data,
    output logic                           node_train,
    output logic [COUNT-1:0]               node_forward_valid,
    output logic [DEPTH*WIDTH-1:0]         node_forward_data,
    input  logic [COUNT-1:0]               node_forward_ready,
    input  logic [COUNT-1:0]               node_output_valid,
    input  logic [COUNT*WIDTH-1:0]         node_output_data,
    output logic [COUNT-1:0]               node_output_ready,
    output logic                           output_forward_valid,
    input  logic                           output_forward_ready,
    output logic [COUNT*WIDTH-1:0]         output_forward_data,
    input  logic                           input_backward_valid,
    output logic                           input_backward_ready,
    input  logic [COUNT*2*WIDTH-1:0]       input_backward_data,
    output logic [COUNT-1:0]               node_backward_valid,
    output logic [COUNT*2*WIDTH-1:0]       node_backward_data,
    input  logic [COUNT-1:0]               node_backward_ready,
    input  logic [COUNT-1:0]               node_error_valid,
    input  logic [COUNT*DEPTH*2*WIDTH-1:0] node_error_data,
    output logic [COUNT-1:0]               node_error_ready,
    output logic                           output_backward_valid,
    input  logic                           output_backward_ready,
    output logic [DEPTH*2*WIDTH-1:0]       output_backward_data
);
    localparam int EW = 2 * WIDTH;
    localparam int CW = $clog2(COUNT);

    typedef enum logic [3:0] {
        IDLE, SCATTER, GATHER, EMIT, DELTA, DISTRIBUTE, COLLECT, REDUCE, RETURN
    } state_t;

    state_t state, state_next;
    logic [DEPTH*WIDTH-1:0] sample;
    logic [COUNT*EW-1:0]    error_in;
    logic [WIDTH-1:0]       activation [COUNT];
    logic [EW-1:0]          error_slot [COUNT][DEPTH];
    logic [EW-1:0]          acc [DEPTH];
    logic [COUNT-1:0]       forward_sent, forward_got, backward_sent, backward_got;
    logic [COUNT-1:0]       forward_sent_next, forward_got_next, backward_sent_next, backward_got_next;
    logic [CW-1:0]          index;
    logic                   forward_accept, backward_accept, reduce_start;

    function automatic logic [EW-1:0] add(input logic [EW-1:0] a, input logic [EW-1:0] b);
`ifdef LAYER_SEQUENCER_SATURATE_EN
        logic [EW:0] s;
        s = {a[EW-1], a} + {b[EW-1], b};
        return (s[EW] != s[EW-1]) ? {s[EW], {(EW-1){~s[EW]}}} : s[EW-1:0];
`else
        return a + b;
`endif
    endfunction

    assign input_forward_ready   = reset & (state == IDLE);
    assign node_forward_valid    = (state == SCATTER) ? ~forward_sent : '0;
    assign node_output_ready     = (state == SCATTER || state == GATHER) ? forward_sent & ~forward_got : '0;
    assign output_forward_valid  = state == EMIT;
    assign input_backward_ready  = state == DELTA;
    assign node_backward_valid   = (state == DISTRIBUTE) ? ~backward_sent : '0;
    assign node_error_ready      = (state == DISTRIBUTE || state == COLLECT) ? backward_sent & ~backward_got : '0;
    assign output_backward_valid = state == RETURN;
    assign node_forward_data     = sample;
    assign node_backward_data    = error_in;

    assign forward_accept     = input_forward_valid & input_forward_ready;
    assign backward_accept    = input_backward_valid & input_backward_ready;
    assign forward_sent_next  = forward_sent | (node_forward_valid & node_forward_ready);
    assign forward_got_next   = forward_got | (node_output_valid & node_output_ready);
    assign backward_sent_next = backward_sent | (node_backward_valid & node_backward_ready);
    assign backward_got_next  = backward_got | (node_error_valid & node_error_ready);
    assign reduce_start       = (state == COLLECT) && (&backward_got_next);

    for (genvar k = 0; k < COUNT; k++) begin : g_join
        assign output_forward_data[k*WIDTH +: WIDTH] = activation[k];
    end
    for (genvar d = 0; d < DEPTH; d++) begin : g_reduce
        assign output_backward_data[d*EW +: EW] = acc[d];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = input_forward_valid ? SCATTER : IDLE;
            SCATTER:    state_next = (&forward_sent_next) ? GATHER : SCATTER;
            GATHER:     state_next = (&forward_got_next) ? EMIT : GATHER;
            EMIT:       state_next = !output_forward_ready ? EMIT : (node_train ? DELTA : IDLE);
            DELTA:      state_next = input_backward_valid ? DISTRIBUTE : DELTA;
            DISTRIBUTE: state_next = (&backward_sent_next) ? COLLECT : DISTRIBUTE;
            COLLECT:    state_next = reduce_start ? REDUCE : COLLECT;
            REDUCE:     state_next = (index == CW'(COUNT - 1)) ? RETURN : REDUCE;
            RETURN:     state_next = output_backward_ready ? IDLE : RETURN;
            default:    state_next = IDLE;
        endcase
    end

    // Capture paths stay open outside their states too; the ready masks gate them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample        <= '0;
            node_train    <= 1'b0;
            error_in      <= '0;
            forward_sent  <= '0;
            forward_got   <= '0;
            backward_sent <= '0;
            backward_got  <= '0;
            index         <= '0;
            for (int k = 0; k < COUNT; k++) begin
                activation[k] <= '0;
                for (int d = 0; d < DEPTH; d++) error_slot[k][d] <= '0;
            end
            for (int d = 0; d < DEPTH; d++) acc[d] <= '0;
        end else begin
            if (forward_accept) begin
                sample     <= input_forward_data;
                node_train <= train;
            end
            if (backward_accept) error_in <= input_backward_data;
            forward_sent  <= forward_accept ? '0 : forward_sent_next;
            forward_got   <= forward_accept ? '0 : forward_got_next;
            backward_sent <= backward_accept ? '0 : backward_sent_next;
            backward_got  <= backward_accept ? '0 : backward_got_next;
            for (int k = 0; k < COUNT; k++) begin
                if (node_output_valid[k] && node_output_ready[k])
                    activation[k] <= node_output_data[k*WIDTH +: WIDTH];
                if (node_error_valid[k] && node_error_ready[k])
                    for (int d = 0; d < DEPTH; d++)
                        error_slot[k][d] <= node_error_data[(k*DEPTH+d)*EW +: EW];
            end
            if (reduce_start) begin
                index <= '0;
                for (int d = 0; d < DEPTH; d++) acc[d] <= '0;
            end else if (state == REDUCE) begin
                index <= index + 1'b1;
                for (int d = 0; d < DEPTH; d++) acc[d] <= add(acc[d], error_slot[index][d]);
            end
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized and directed bench for layer_sequencer against a transaction-level model.
module tb_layer_sequencer;
    localparam int W = 8, D = 2, C = 2, EW = 2 * W;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic train = 1'b0;
    logic input_forward_valid = 1'b0;
    logic input_forward_ready;
    logic [D*W-1:0] input_forward_data = '0;
    logic node_train;
    logic [C-1:0] node_forward_valid;
    logic [D*W-1:0] node_forward_data;
    logic [C-1:0] node_forward_ready = '0;
    logic [C-1:0] node_output_valid = '0;
    logic [C*W-1:0] node_output_data = '0;
    logic [C-1:0] node_output_ready;
    logic output_forward_valid;
    logic output_forward_ready = 1'b0;
    logic [C*W-1:0] output_forward_data;
    logic input_backward_valid = 1'b0;
    logic input_backward_ready;
    logic [C*EW-1:0] input_backward_data = '0;
    logic [C-1:0] node_backward_valid;
    logic [C*EW-1:0] node_backward_data;
    logic [C-1:0] node_backward_ready = '0;
    logic [C-1:0] node_error_valid = '0;
    logic [C*D*EW-1:0] node_error_data = '0;
    logic [C-1:0] node_error_ready;
    logic output_backward_valid;
    logic output_backward_ready = 1'b0;
    logic [D*EW-1:0] output_backward_data;

    layer_sequencer #(.WIDTH(W), .DEPTH(D), .COUNT(C)) dut (
        .clock(clock), .reset(reset), .train(train),
        .input_forward_valid(input_forward_valid), .input_forward_ready(input_forward_ready),
        .input_forward_data(input_forward_data), .node_train(node_train),
        .node_forward_valid(node_forward_valid), .node_forward_data(node_forward_data),
        .node_forward_ready(node_forward_ready), .node_output_valid(node_output_valid),
        .node_output_data(node_output_data), .node_output_ready(node_output_ready),
        .output_forward_valid(output_forward_valid), .output_forward_ready(output_forward_ready),
        .output_forward_data(output_forward_data), .input_backward_valid(input_backward_valid),
        .input_backward_ready(input_backward_ready), .input_backward_data(input_backward_data),
        .node_backward_valid(node_backward_valid), .node_backward_data(node_backward_data),
        .node_backward_ready(node_backward_ready), .node_error_valid(node_error_valid),
        .node_error_data(node_error_data), .node_error_ready(node_error_ready),
        .output_backward_valid(output_backward_valid), .output_backward_ready(output_backward_ready),
        .output_backward_data(output_backward_data)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0, cyc = 0;
    logic [W-1:0] smp [D];
    logic [W-1:0] outv [C];
    logic [EW-1:0] berr [C];
    logic [EW-1:0] nerr [C][D];
    int fw [C], ow [C], bw [C], ew [C], gcyc [C];
    int bp;
    bit tr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    function automatic logic [D*W-1:0] smp_vec();
        logic [D*W-1:0] v;
        for (int d = 0; d < D; d++) v[d*W +: W] = smp[d];
        return v;
    endfunction

    function automatic logic [C*W-1:0] out_vec();
        logic [C*W-1:0] v;
        for (int k = 0; k < C; k++) v[k*W +: W] = outv[k];
        return v;
    endfunction

    function automatic logic [C*EW-1:0] berr_vec();
        logic [C*EW-1:0] v;
        for (int k = 0; k < C; k++) v[k*EW +: EW] = berr[k];
        return v;
    endfunction

    // Sum of every node's error per input, applying the range rule after each addition.
    function automatic logic [D*EW-1:0] ref_reduce();
        logic [D*EW-1:0] r;
        int acc;
        int lim;
        lim = 1 << (EW - 1);
        r = '0;
        for (int d = 0; d < D; d++) begin
            acc = 0;
            for (int k = 0; k < C; k++) begin
                acc += int'($signed(nerr[k][d]));
`ifdef LAYER_SEQUENCER_SATURATE_EN
                if (acc > lim - 1) acc = lim - 1;
                else if (acc < -lim) acc = -lim;
`else
                acc = ((acc + lim) & (2 * lim - 1)) - lim;
`endif
            end
            r[d*EW +: EW] = EW'(acc);
        end
        return r;
    endfunction

    // Behavioural nodes: each accepts its request after a latency, then answers after another latency.
    task automatic node_phase(input bit bwd, output int last);
        bit sd [C];
        bit gd [C];
        int sc [C], ls [C], lg [C];
        int n, ng;
        bit sr, gv;
        logic [C-1:0] v, r;
        n = 0;
        ng = 0;
        last = 0;
        for (int k = 0; k < C; k++) begin
            sd[k] = 0;
            gd[k] = 0;
            sc[k] = -10;
            ls[k] = bwd ? bw[k] : fw[k];
            lg[k] = bwd ? ew[k] : ow[k];
            node_output_data[k*W +: W] = outv[k];
            for (int d = 0; d < D; d++) node_error_data[(k*D+d)*EW +: EW] = nerr[k][d];
        end
        while (ng < C && n < 200) begin
            v = bwd ? node_backward_valid : node_forward_valid;
            r = bwd ? node_error_ready : node_output_ready;
            for (int k = 0; k < C; k++) begin
                sr = 0;
                gv = 0;
                if (!sd[k]) begin
                    if (v[k] && ls[k] == 0) begin
                        sr = 1;
                        sd[k] = 1;
                        sc[k] = cyc;
                        if (bwd) check("bwd_data", node_backward_data[k*EW +: EW], berr[k]);
                        else check("fwd_data", node_forward_data, smp_vec());
                    end else if (v[k]) ls[k]--;
                end else if (!gd[k]) begin
                    if (sc[k] == cyc - 1) check(bwd ? "bwd_drop" : "fwd_drop", v[k], 0);
                    if (lg[k] > 0) lg[k]--;
                    else begin
                        gv = 1;
                        if (r[k]) begin
                            gd[k] = 1;
                            gcyc[k] = cyc;
                            last = cyc;
                            ng++;
                        end
                    end
                end
                if (bwd) begin
                    node_backward_ready[k] = sr;
                    node_error_valid[k] = gv;
                end else begin
                    node_forward_ready[k] = sr;
                    node_output_valid[k] = gv;
                end
            end
            tick();
            n++;
        end
        check(bwd ? "bwd_got" : "fwd_got", ng, C);
        node_forward_ready = '0;
        node_output_valid = '0;
        node_backward_ready = '0;
        node_error_valid = '0;
    endtask

    task automatic run_txn();
        int t0, last, n, hold;
        bit zl;
        logic [C*W-1:0] ov;
        logic [D*EW-1:0] rv;
        zl = 1;
        for (int k = 0; k < C; k++) if (fw[k] != 0 || ow[k] != 0) zl = 0;
        train = tr;
        input_forward_data = smp_vec();
        input_forward_valid = 1;
        n = 0;
        while (!input_forward_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready", input_forward_ready, 1);
        t0 = cyc;
        tick();
        input_forward_valid = 0;
        train = ~tr;
        check("scatter_c1", node_forward_valid, {C{1'b1}});
        node_phase(0, last);
        check("emit_valid", output_forward_valid, 1);
        if (zl) check("emit_c3", cyc - t0, 3);
        ov = out_vec();
        for (int i = 0; i < bp; i++) begin
            check("emit_hold", output_forward_valid, 1);
            check("emit_stable", output_forward_data, ov);
            check("in_blocked", input_forward_ready, 0);
            tick();
        end
        check("emit_data", output_forward_data, ov);
        output_forward_ready = 1;
        tick();
        output_forward_ready = 0;
        check("emit_once", output_forward_valid, 0);
        check("train_latch", node_train, tr);
        if (!tr) begin
            check("no_delta", input_backward_ready, 0);
            check("idle", input_forward_ready, 1);
            return;
        end
        check("delta", input_backward_ready, 1);
        input_backward_data = berr_vec();
        input_backward_valid = 1;
        tick();
        input_backward_valid = 0;
        node_phase(1, last);
        n = 0;
        while (!output_backward_valid && n < 20) begin
            tick();
            n++;
        end
        check("reduce_lat", cyc - last, C + 1);
        rv = ref_reduce();
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            check("ret_stable", output_backward_data, rv);
            tick();
        end
        check("ret_data", output_backward_data, rv);
        check("ret_valid", output_backward_valid, 1);
        output_backward_ready = 1;
        tick();
        output_backward_ready = 0;
        check("ret_once", output_backward_valid, 0);
        check("idle", input_forward_ready, 1);
    endtask

    task automatic randomize_txn();
        tr = 1'($urandom);
        bp = $urandom_range(0, 3);
        for (int d = 0; d < D; d++) smp[d] = W'($urandom);
        for (int k = 0; k < C; k++) begin
            outv[k] = W'($urandom);
            berr[k] = EW'($urandom);
            fw[k] = $urandom_range(0, 3);
            ow[k] = $urandom_range(0, 3);
            bw[k] = $urandom_range(0, 3);
            ew[k] = $urandom_range(0, 3);
            for (int d = 0; d < D; d++) nerr[k][d] = EW'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ifr"}, input_forward_ready, 0);
        check({tag, "_nfv"}, node_forward_valid, 0);
        check({tag, "_nor"}, node_output_ready, 0);
        check({tag, "_ofv"}, output_forward_valid, 0);
        check({tag, "_ibr"}, input_backward_ready, 0);
        check({tag, "_nbv"}, node_backward_valid, 0);
        check({tag, "_ner"}, node_error_ready, 0);
        check({tag, "_obv"}, output_backward_valid, 0);
        check({tag, "_ntr"}, node_train, 0);
    endtask

    initial begin
        tick();
        tick();
        check_quiet("rst");
        check("rst_ofd", output_forward_data, 0);
        check("rst_obd", output_backward_data, 0);
        reset = 1;
        tick();
        check("rst_release", input_forward_ready, 1);

        randomize_txn();
        tr = 0; bp = 0;
        smp[0] = 8'h10; smp[1] = 8'h20;
        outv[0] = 8'h80; outv[1] = 8'h7F;
        fw[0] = 0; fw[1] = 3; ow[0] = 0; ow[1] = 0;
        run_txn();

        randomize_txn();
        tr = 0;
        fw[0] = 4; fw[1] = 0; ow[0] = 0; ow[1] = 0;
        run_txn();
        check("ooo_order", gcyc[1] < gcyc[0], 1);

        randomize_txn();
        tr = 1;
        for (int k = 0; k < C; k++) begin fw[k] = 0; ow[k] = 0; end
        nerr[0][0] = 16'h0100; nerr[0][1] = 16'hFF00;
        nerr[1][0] = 16'h0050; nerr[1][1] = 16'h0010;
        run_txn();

        randomize_txn();
        tr = 1;
        nerr[0][0] = 16'h7000; nerr[0][1] = 16'h8000;
        nerr[1][0] = 16'h7000; nerr[1][1] = 16'h8000;
        run_txn();

        randomize_txn();
        tr = 0; bp = 5;
        run_txn();

        train = 1;
        input_forward_data = D*W'($urandom);
        input_forward_valid = 1;
        node_forward_ready = '1;
        tick();
        input_forward_valid = 0;
        tick();
        check("gather", node_output_ready, {C{1'b1}});
        #2 reset = 0;
        #1 check_quiet("abort");
        node_forward_ready = '0;
        train = 0;
        tick();
        tick();
        reset = 1;
        tick();
        check("abort_ready", input_forward_ready, 1);
        check("abort_stale", output_forward_valid, 0);

        for (int i = 0; i < 25; i++) begin
            randomize_txn();
            run_txn();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
